os_collector: RTL and testbench

OS_COLLECTOR -- requirements
Module: os_collector

---
 rtl/os_collector.sv | 135 +++++++++++++
 tb/tb_os_collector.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/os_collector.sv
// Output-stationary collector: gathers one result per mac_tile column into a row and queues rows in a FWFT FIFO.
// Optional sticky overflow detection is compiled in when OS_COLLECT_OVF_EN is defined.
module os_collector #(
  parameter int psum_bw = 16,
  parameter int col     = 8,
  parameter int depth   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   toggle,
  input  logic [col*psum_bw-1:0] os_out,
  input  logic [col-1:0]         os_valid,
  output logic [col*psum_bw-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             row_cnt,
  output logic                   ovf,
  output logic                   busy
);

  localparam int aw = $clog2(depth);
  localparam int cw = aw + 1;
  localparam int rw = col * psum_bw;

  typedef enum logic [1:0] {IDLE, COLLECT, WAIT_FULL} state_t;

  state_t             state_reg;
  logic [col-1:0]     prev_reg;
  logic [col-1:0]     pend_reg;
  logic [col-1:0]     pend_next;
  logic [col-1:0]     rise;
  logic [psum_bw-1:0] cap_reg  [col];
  logic [psum_bw-1:0] cap_next [col];
  logic [rw-1:0]      row_data;

  logic [rw-1:0]      mem [depth];
  logic [aw-1:0]      wr_ptr_reg;
  logic [aw-1:0]      rd_ptr_reg;
  logic [cw-1:0]      count_reg;
  logic [7:0]         row_cnt_reg;

  logic all_pend;
  logic full;
  logic empty;
  logic push;
  logic pop;

  assign all_pend = &pend_reg;
  assign full     = (count_reg == cw'(depth));
  assign empty    = (count_reg == '0);
  // Fullness is judged on the registered count, so a same-cycle pop never frees room for a push.
  assign push     = all_pend & ~full & toggle & (state_reg != IDLE);
  assign pop      = ~empty & out_ready;

  generate
    for (genvar gi = 0; gi < col; gi++) begin : g_col
      assign rise[gi]      = os_valid[gi] & ~prev_reg[gi] & toggle;
      // A new value is accepted only into an empty slot or one being drained by this cycle's push.
      assign cap_next[gi]  = (rise[gi] && (!pend_reg[gi] || push)) ?
                             os_out[gi*psum_bw +: psum_bw] : cap_reg[gi];
      assign pend_next[gi] = rise[gi] ? 1'b1 : (push ? 1'b0 : pend_reg[gi]);
      assign row_data[gi*psum_bw +: psum_bw] = cap_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset || !toggle) begin
      prev_reg <= '0;
      pend_reg <= '0;
      for (int i = 0; i < col; i++) cap_reg[i] <= '0;
    end else begin
      prev_reg <= os_valid;
      pend_reg <= pend_next;
      for (int i = 0; i < col; i++) cap_reg[i] <= cap_next[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else if (!toggle) begin
      state_reg <= IDLE;
    end else begin
      case (state_reg)
        IDLE:      state_reg <= COLLECT;
        COLLECT:   if (all_pend && full) state_reg <= WAIT_FULL;
        WAIT_FULL: if (push) state_reg <= COLLECT;
        default:   state_reg <= IDLE;
      endcase
    end
  end

  // Storage array carries no reset; validity is tracked purely by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= row_data;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      row_cnt_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + aw'(1);
      if (pop) begin
        rd_ptr_reg  <= rd_ptr_reg + aw'(1);
        row_cnt_reg <= row_cnt_reg + 8'd1;
      end
      count_reg <= count_reg + cw'(push) - cw'(pop);
    end
  end

`ifdef OS_COLLECT_OVF_EN
  logic ovf_reg;
  logic any_drop;

  assign any_drop = (|(rise & pend_reg)) & ~push;

  always_ff @(posedge clk) begin
    if (!reset) ovf_reg <= 1'b0;
    else if (any_drop) ovf_reg <= 1'b1;
  end

  assign ovf = ovf_reg;
`else
  assign ovf = 1'b0;
`endif

  assign out_valid = ~empty;
  assign out_data  = empty ? '0 : mem[rd_ptr_reg];
  assign row_cnt   = row_cnt_reg;
  assign busy      = (|pend_reg) | ~empty;

endmodule

// File: tb/tb_os_collector.sv
// Directed self-checking bench for os_collector (col=8, psum_bw=16, depth=4).
module tb_os_collector;

  localparam int PB  = 16;
  localparam int COL = 8;
  localparam int DEP = 4;
  localparam int W   = COL * PB;
`ifdef OS_COLLECT_OVF_EN
  localparam logic EXP_OVF = 1'b1;
`else
  localparam logic EXP_OVF = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic           toggle;
  logic [W-1:0]   os_out;
  logic [COL-1:0] os_valid;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready;
  logic [7:0]     row_cnt;
  logic           ovf;
  logic           busy;

  int total = 0;
  int bad   = 0;

  os_collector #(.psum_bw(PB), .col(COL), .depth(DEP)) dut (
    .clk(clk), .reset(reset), .toggle(toggle), .os_out(os_out),
    .os_valid(os_valid), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .row_cnt(row_cnt), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, expv);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] exp_row;
  logic [W-1:0] rows [5];
  int idx;

  initial begin
    reset = 1'b0; toggle = 1'b0; os_out = '0; os_valid = '0; out_ready = 1'b0;
    tick(); tick();
    check("rst_valid", W'(out_valid), W'(0));
    check("rst_data",  out_data, '0);
    check("rst_busy",  W'(busy), W'(0));
    check("rst_ovf",   W'(ovf), W'(0));
    check("rst_rowcnt", W'(row_cnt), W'(0));

    // All columns rise together with values 1..8
    reset = 1'b1; toggle = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < COL; i++) os_out[i*PB +: PB] = PB'(i + 1);
    exp_row = os_out;
    os_valid = '1;
    tick();
    check("one_edge_valid", W'(out_valid), W'(0));
    check("one_edge_busy",  W'(busy), W'(1));
    tick();
    check("two_edge_valid", W'(out_valid), W'(1));
    check("two_edge_data",  out_data, exp_row);
    tick();
    check("pop1_rowcnt", W'(row_cnt), W'(1));
    check("pop1_valid",  W'(out_valid), W'(0));
    check("pop1_busy",   W'(busy), W'(0));

    // Staggered column rises: no partial push
    os_valid = '0;
    tick();
    for (int k = 0; k < COL; k++) begin
      os_out[k*PB +: PB] = PB'(16'h0100 + k);
      os_valid[k] = 1'b1;
      tick();
      check($sformatf("stag_nopush_c%0d", k), W'(out_valid), W'(0));
    end
    for (int i = 0; i < COL; i++) exp_row[i*PB +: PB] = PB'(16'h0100 + i);
    tick();
    check("stag_valid", W'(out_valid), W'(1));
    check("stag_data",  out_data, exp_row);
    tick();
    check("stag_rowcnt", W'(row_cnt), W'(2));

    // Five rows into a four-deep FIFO with no consumer
    out_ready = 1'b0;
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < COL; i++) rows[r][i*PB +: PB] = PB'((r << 8) | (i + 16'h0a0));
    end
    for (int r = 0; r < 5; r++) begin
      os_valid = '0;
      tick();
      os_out = rows[r];
      os_valid = '1;
      tick();
    end
    tick();
    check("full_valid", W'(out_valid), W'(1));
    check("full_busy",  W'(busy), W'(1));
    check("full_head",  out_data, rows[0]);
    tick(); tick();
    check("full_head_stable", out_data, rows[0]);
    out_ready = 1'b1;
    idx = 0;
    for (int c = 0; c < 20; c++) begin
      if (out_valid) begin
        if (idx < 5) check($sformatf("drain_row%0d", idx), out_data, rows[idx]);
        idx++;
      end
      tick();
    end
    check("drain_count",  W'(idx), W'(5));
    check("drain_rowcnt", W'(row_cnt), W'(7));
    check("drain_empty",  W'(out_valid), W'(0));

    // Column 3 rises twice before the row completes
    os_valid = '0;
    tick();
    os_out[3*PB +: PB] = 16'h0011;
    os_valid = 8'h08;
    tick();
    os_valid = '0;
    tick();
    os_out[3*PB +: PB] = 16'h0022;
    os_valid = 8'h08;
    tick();
    check("dup_ovf",  W'(ovf), W'(EXP_OVF));
    check("dup_busy", W'(busy), W'(1));
    for (int i = 0; i < COL; i++) if (i != 3) os_out[i*PB +: PB] = PB'(16'h0030 + i);
    for (int i = 0; i < COL; i++) exp_row[i*PB +: PB] = (i == 3) ? 16'h0011 : PB'(16'h0030 + i);
    os_valid = '1;
    tick();
    tick();
    check("dup_valid", W'(out_valid), W'(1));
    check("dup_data",  out_data, exp_row);
    tick();
    check("dup_rowcnt", W'(row_cnt), W'(8));
    check("dup_ovf_sticky", W'(ovf), W'(EXP_OVF));

    // Level held high: single capture only
    for (int c = 0; c < 10; c++) tick();
    check("hold_valid",  W'(out_valid), W'(0));
    check("hold_busy",   W'(busy), W'(0));
    check("hold_rowcnt", W'(row_cnt), W'(8));

    // Reset mid-operation with a held row and a partial row
    out_ready = 1'b0;
    os_valid = '0;
    tick();
    os_valid = '1;
    tick();
    os_valid = '0;
    tick();
    os_valid = 8'h0f;
    tick();
    check("mid_busy",  W'(busy), W'(1));
    check("mid_valid", W'(out_valid), W'(1));
    reset = 1'b0;
    tick();
    check("mid_rst_valid",  W'(out_valid), W'(0));
    check("mid_rst_data",   out_data, '0);
    check("mid_rst_busy",   W'(busy), W'(0));
    check("mid_rst_rowcnt", W'(row_cnt), W'(0));
    check("mid_rst_ovf",    W'(ovf), W'(0));
    os_valid = '0;
    reset = 1'b1;
    tick();
    check("post_rst_busy", W'(busy), W'(0));

    // Dropping toggle discards a partial row
    os_valid = 8'h03;
    tick();
    check("tog_partial_busy", W'(busy), W'(1));
    toggle = 1'b0;
    tick();
    check("tog_off_busy",  W'(busy), W'(0));
    check("tog_off_valid", W'(out_valid), W'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
